// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, 7/8 data bits, optional even/odd parity,
// and a first-word-fall-through FIFO storing {ferr, perr, data} per frame.
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_in,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          bit8,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          rd_en,
    input  logic                          ovr_clr,
    output logic [7:0]                    rd_data,
    output logic                          rd_perr,
    output logic                          rd_ferr,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overrun,
    output logic                          rx_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q;
    logic [1:0]       sync_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic [3:0]       os_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       data_q;
    logic             perr_q;
    logic             bit8_q;
    logic             par_en_q;
    logic             par_odd_q;
    logic             busy_q;
    logic             push_q;
    logic [9:0]       push_word_q;

    logic rxs;
    logic tick;

    assign rxs  = sync_q[1];
    assign tick = (div_cnt_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= 2'b11;
            state_q     <= S_IDLE;
            div_cnt_q   <= '0;
            os_q        <= '0;
            bit_cnt_q   <= '0;
            data_q      <= '0;
            perr_q      <= 1'b0;
            bit8_q      <= 1'b0;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            busy_q      <= 1'b0;
            push_q      <= 1'b0;
            push_word_q <= '0;
        end else begin
            sync_q    <= {sync_q[0], rx_in};
            push_q    <= 1'b0;
            div_cnt_q <= tick ? baud_div : div_cnt_q - DIV_W'(1);
            if (tick) begin
                os_q <= os_q + 4'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (!rxs) begin
                        // Reload aligns the tick phase to the detected start edge.
                        state_q   <= S_START;
                        busy_q    <= 1'b1;
                        div_cnt_q <= baud_div;
                        os_q      <= '0;
                        bit_cnt_q <= '0;
                        data_q    <= '0;
                        perr_q    <= 1'b0;
                        bit8_q    <= bit8;
                        par_en_q  <= parity_en;
                        par_odd_q <= parity_odd;
                    end
                end
                S_START: begin
                    if (tick && os_q == 4'd7) begin
                        os_q <= '0;
                        if (rxs) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (tick && os_q == 4'd15) begin
                        os_q              <= '0;
                        data_q[bit_cnt_q] <= rxs;
                        bit_cnt_q         <= bit_cnt_q + 3'd1;
                        // Last index is 7 in 8-bit mode, 6 in 7-bit mode.
                        if (bit_cnt_q == {2'b11, bit8_q}) begin
                            state_q <= par_en_q ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick && os_q == 4'd15) begin
                        os_q    <= '0;
                        perr_q  <= (^data_q) ^ rxs ^ par_odd_q;
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick && os_q == 4'd15) begin
                        os_q        <= '0;
                        push_q      <= 1'b1;
                        push_word_q <= {~rxs, perr_q, data_q};
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_busy = busy_q;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          overrun_q;
    logic          do_pop;
    logic          do_push;
    logic          ovr_set;
    logic [9:0]    head;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign do_pop  = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the frame.
    assign do_push = push_q && (!full || do_pop);
    assign ovr_set = push_q && full && !do_pop;

    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LW'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            level_q <= level_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (ovr_set) begin
                overrun_q <= 1'b1;
            end else if (ovr_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_word_q;
        end
    end

    assign head    = mem[rd_ptr_q];
    assign rd_data = empty ? 8'h00 : head[7:0];
    assign rd_perr = empty ? 1'b0 : head[8];
    assign rd_ferr = empty ? 1'b0 : head[9];
    assign level   = level_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios then randomized frames, all checked
// against a queue-based model of the receive FIFO and per-frame error flags.
module tb_uart_rx_fifo;
  localparam int DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        rx_in;
  logic [15:0] baud_div;
  logic        bit8;
  logic        parity_en;
  logic        parity_odd;
  logic        rd_en;
  logic        ovr_clr;
  logic [7:0]  rd_data;
  logic        rd_perr;
  logic        rd_ferr;
  logic        empty;
  logic        full;
  logic [2:0]  level;
  logic        overrun;
  logic        rx_busy;

  uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
    .clk(clk), .reset(reset), .rx_in(rx_in), .baud_div(baud_div),
    .bit8(bit8), .parity_en(parity_en), .parity_odd(parity_odd),
    .rd_en(rd_en), .ovr_clr(ovr_clr), .rd_data(rd_data), .rd_perr(rd_perr),
    .rd_ferr(rd_ferr), .empty(empty), .full(full), .level(level),
    .overrun(overrun), .rx_busy(rx_busy)
  );

  // scoreboard
  logic [9:0] exp_q[$];
  bit         m_ovr;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  bit         drv_busy = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: count ones over data (+parity bit); even parity wants an even total.
  function automatic logic [9:0] exp_entry(input logic [7:0] d, input bit b8, input bit pen,
                                           input bit podd, input bit pbit, input bit stop);
    logic [7:0] v;
    int ones;
    bit perr;
    v = b8 ? d : {1'b0, d[6:0]};
    ones = $countones(v) + (pen ? int'(pbit) : 0);
    perr = pen && ((ones % 2) != int'(podd));
    return {!stop, perr, v};
  endfunction

  task automatic model_push(input logic [9:0] e);
    if (exp_q.size() == DEPTH) m_ovr = 1'b1;
    else exp_q.push_back(e);
  endtask

  task automatic check_model(input string tag);
    logic [9:0] h;
    h = (exp_q.size() != 0) ? exp_q[0] : 10'd0;
    check({tag, ".empty"}, empty, exp_q.size() == 0);
    check({tag, ".level"}, level, exp_q.size());
    check({tag, ".full"}, full, exp_q.size() == DEPTH);
    check({tag, ".overrun"}, overrun, m_ovr);
    check({tag, ".rd_data"}, rd_data, h[7:0]);
    check({tag, ".rd_perr"}, rd_perr, h[8]);
    check({tag, ".rd_ferr"}, rd_ferr, h[9]);
  endtask

  // driver tasks (entered on a negedge, return on a negedge)
  task automatic send_frame(input logic [7:0] d, input bit b8, input bit pen,
                            input bit pbit, input bit stop);
    int bc;
    bc = 16 * (int'(baud_div) + 1);
    drv_busy = 1'b1;
    rx_in = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < (b8 ? 8 : 7); i++) begin
      rx_in = d[i];
      repeat (bc) @(negedge clk);
    end
    if (pen) begin
      rx_in = pbit;
      repeat (bc) @(negedge clk);
    end
    rx_in = stop;
    repeat (bc) @(negedge clk);
    rx_in = 1'b1;
    drv_busy = 1'b0;
  endtask

  task automatic idle_bit();
    repeat (16 * (int'(baud_div) + 1)) @(negedge clk);
  endtask

  task automatic do_frame(input string tag, input logic [7:0] d, input bit pbit, input bit stop);
    send_frame(d, bit8, parity_en, pbit, stop);
    model_push(exp_entry(d, bit8, parity_en, parity_odd, pbit, stop));
    idle_bit();
    check_model(tag);
  endtask

  task automatic pop_one(input string tag);
    logic [9:0] tmp;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (exp_q.size() != 0) tmp = exp_q.pop_front();
    check_model(tag);
  endtask

  task automatic wait_drv(input string tag);
    int t;
    t = 0;
    while (drv_busy && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check({tag, ".drv_done"}, drv_busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int t;
    bit saw_busy;
    logic [9:0] tmp;

    reset = 1'b1; rx_in = 1'b1; baud_div = 16'd0; bit8 = 1'b1; parity_en = 1'b0;
    parity_odd = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0; m_ovr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_model("reset");
    check("reset.busy", rx_busy, 1'b0);

    // 8N1, 16 clk/bit, with latency measurement from the start edge
    fork
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    join_none
    lat = 0;
    while (empty && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check("8n1.latency_window", (lat >= 150 && lat <= 160), 1'b1);
    model_push(exp_entry(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    wait_drv("8n1");
    check_model("8n1");
    check("8n1.data_const", rd_data, 8'hA5);
    pop_one("8n1.pop");

    // 7E1 / 7O1 at 64 clk/bit
    baud_div = 16'd3; bit8 = 1'b0; parity_en = 1'b1; parity_odd = 1'b0;
    do_frame("7e1.ok", 8'h41, 1'b0, 1'b1);
    check("7e1.ok.perr_const", rd_perr, 1'b0);
    pop_one("7e1.ok.pop");
    do_frame("7e1.bad", 8'h41, 1'b1, 1'b1);
    check("7e1.bad.perr_const", rd_perr, 1'b1);
    pop_one("7e1.bad.pop");
    parity_odd = 1'b1;
    do_frame("7o1.ok", 8'h41, 1'b1, 1'b1);
    pop_one("7o1.ok.pop");

    // framing error, then a clean frame
    baud_div = 16'd0; bit8 = 1'b1; parity_en = 1'b0; parity_odd = 1'b0;
    do_frame("ferr", 8'h3C, 1'b0, 1'b0);
    check("ferr.ferr_const", rd_ferr, 1'b1);
    idle_bit();
    do_frame("after_ferr", 8'hC3, 1'b0, 1'b1);
    pop_one("after_ferr.pop1");
    pop_one("after_ferr.pop2");

    // false start: 4 clocks low
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    rx_in = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rx_busy) saw_busy = 1'b1;
      @(negedge clk);
    end
    check("false_start.busy_pulse", saw_busy, 1'b1);
    check("false_start.busy_idle", rx_busy, 1'b0);
    check_model("false_start");

    // overrun with a 4-entry FIFO
    for (int i = 1; i <= 4; i++) do_frame("fill", 8'(i), 1'b0, 1'b1);
    check("fill.full_const", full, 1'b1);
    do_frame("ovr", 8'h05, 1'b0, 1'b1);
    check("ovr.overrun_const", overrun, 1'b1);
    for (int i = 0; i < 4; i++) pop_one("ovr.drain");
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    m_ovr = 1'b0;
    check_model("ovr_clr");

    // push coincident with a pop while full
    for (int i = 0; i < 4; i++) do_frame("refill", 8'h11 + 8'(i), 1'b0, 1'b1);
    fork
      send_frame(8'h15, 1'b1, 1'b0, 1'b0, 1'b1);
    join_none
    t = 0;
    while (!rx_busy && t < 100) begin @(negedge clk); t++; end
    while (rx_busy && t < 400) begin @(negedge clk); t++; end
    check("coinc.busy_seen", t < 400, 1'b1);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    tmp = exp_q.pop_front();
    exp_q.push_back(exp_entry(8'h15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    check_model("coinc");
    wait_drv("coinc");
    for (int i = 0; i < 4; i++) pop_one("coinc.drain");

    // reset in the middle of a frame
    do_frame("pre_reset", 8'h66, 1'b0, 1'b1);
    fork
      send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
    join_none
    repeat (60) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    m_ovr = 1'b0;
    check("rst_mid.busy", rx_busy, 1'b0);
    check_model("rst_mid");
    wait_drv("rst_mid");
    reset = 1'b0;
    idle_bit();
    do_frame("post_reset", 8'h99, 1'b0, 1'b1);
    pop_one("post_reset.pop");

    // randomized frames with random configuration, errors and reads
    for (int n = 0; n < 16; n++) begin
      baud_div   = 16'($urandom_range(0, 3));
      bit8       = 1'($urandom_range(0, 1));
      parity_en  = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      do_frame("rand", 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0);
      for (int k = $urandom_range(0, 2); k > 0; k--) pop_one("rand.pop");
      if ($urandom_range(0, 3) == 0) begin
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        m_ovr = 1'b0;
        check_model("rand.ovr_clr");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receive engine with 16x oversampling, configurable 7/8 data bits, none/even/odd parity, per-frame parity and framing error detection, and a first-word-fall-through receive FIFO with overrun tracking. It sits between the external serial line and the PicoBlaze port decoder. It succeeds the single-register receive path: it adds mid-bit majority-free centre sampling, false-start rejection, error flags and buffering.

## Interface
- `FIFO_DEPTH`, default 16: receive FIFO entries; power of two, 2 to 256.
- `DIV_W`, default 16: width of the baud divisor.
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high reset of all state.
- `rx_in`, input, 1: asynchronous serial line; idles high.
- `baud_div`, input, DIV_W: clocks per oversample tick minus 1. Bit period = 16*(baud_div+1) clocks.
- `bit8`, input, 1: 1 = 8 data bits; 0 = 7 data bits.
- `parity_en`, input, 1: 1 = a parity bit follows the data.
- `parity_odd`, input, 1: 1 = odd parity; 0 = even parity.
- `rd_en`, input, 1: pop the FIFO head. Ignored when empty.
- `ovr_clr`, input, 1: clear the sticky overrun flag.
- `rd_data`, output, 8: FIFO head data. Bit 7 is 0 in 7-bit mode. Reads 0 when empty.
- `rd_perr`, output, 1: parity error flag of the head entry. Reads 0 when empty.
- `rd_ferr`, output, 1: framing error flag of the head entry. Reads 0 when empty.
- `empty`, output, 1: FIFO empty.
- `full`, output, 1: FIFO full.
- `level`, output, $clog2(FIFO_DEPTH)+1: number of stored entries.
- `overrun`, output, 1: sticky; set when a frame is dropped because the FIFO is full.
- `rx_busy`, output, 1: FSM is not in IDLE.

## Operation
**Line synchroniser**
- Two-flop synchroniser on `rx_in`.
- Both flops reset to 1.
- All logic uses the synchronised value `rxs`.

**Tick generator**
- Down-counter reloaded with `baud_div`.
- Emits a one-clock `tick` when the count is 0.
- Also reloaded on IDLE→START, so that tick phase is aligned to the start edge.
- A change to `baud_div` takes effect at the next reload.

**Oversample counter**
- 4-bit counter `os`, advanced on `tick`.
- Cleared on every state transition.

**FSM states**
- IDLE: when `rxs`=0, go to START.
- START: on the tick where `os`=7 (mid start bit), sample `rxs`:
  - `rxs`=1: false start; return to IDLE.
  - `rxs`=0: go to DATA with the bit counter at 0.
- DATA: on every tick where `os`=15, shift `rxs` in LSB-first.
  - After 7 bits (`bit8`=0) or 8 bits (`bit8`=1), go to PARITY if `parity_en`=1, else to STOP.
- PARITY: on the tick where `os`=15, sample the parity bit `p`.
  - Even parity: perr = XOR(data bits, p).
  - Odd parity: perr = the inverse of that XOR.
  - Go to STOP.
- STOP: on the tick where `os`=15 (mid stop bit), ferr = ~`rxs`.
  - Push {ferr, perr, data} into the FIFO on the same clock.
  - Go to IDLE, so a start bit may be detected from the second half of the stop bit onward.
- perr is 0 when `parity_en`=0.
- Frames with errors are still stored.
- `bit8`, `parity_en` and `parity_odd` are sampled on IDLE→START and held for the whole frame.

**FIFO**
- Entries are 10 bits wide; memory has FIFO_DEPTH entries.
- Read and write pointers wrap modulo FIFO_DEPTH.
- Reads are first-word-fall-through: `rd_data`, `rd_perr` and `rd_ferr` show the head combinationally when not empty.
- Push while full: the frame is dropped, pointers are unchanged, `overrun` is set.
- Push and `rd_en` in the same cycle while full: both occur; no overrun; `level` is unchanged.
- Push and `rd_en` in the same cycle while empty: the push occurs and the pop is ignored; `level` becomes 1.
- `ovr_clr` and a new overrun in the same cycle: set wins.

## Timing
- Reset values:
  - all outputs: 0, except `empty`=1;
  - FSM in IDLE;
  - pointers and `level` at 0;
  - tick counter reloaded.
- Reset mid-frame abandons the frame; nothing is pushed.
- Start detection: IDLE→START occurs 2–3 clocks after the falling edge on `rx_in` (synchroniser latency).
- Data sample points are nominally 1.5, 2.5, … bit periods after the start edge, i.e. bit centres.
- `empty` falls, and `rd_data` and `level` update, on the clock edge after the stop-sample tick edge.
- A pop takes effect on the clock edge where `rd_en`=1: the next head appears in the same cycle as the updated `level`.
- `full` = (`level` == FIFO_DEPTH).
- `rx_busy` is registered along with the FSM state.

## Test plan
- **8N1 receive.** `baud_div`=0 (16 clk/bit), `bit8`=1, `parity_en`=0; send 0xA5 with stop=1.
  - `empty` falls about 152 clocks after the start edge.
  - `rd_data`=0xA5, `rd_perr`=0, `rd_ferr`=0, `level`=1.
  - `rd_en` pulse → `empty`=1, `rd_data`=0.
- **7E1 and 7O1 parity.** `baud_div`=3, `bit8`=0, `parity_en`=1.
  - Even: send 0x41 with p=0 → `rd_data`=0x41, `rd_perr`=0. Resend with p=1 → `rd_perr`=1.
  - `parity_odd`=1, 0x41 with p=1 → `rd_perr`=0.
- **Framing error.** Send 0x3C with stop=0, then release the line → `rd_data`=0x3C, `rd_ferr`=1. The next valid frame is received correctly.
- **False start.** Drive `rx_in` low for 4 bit-clocks (less than half a bit at 16 clk/bit).
  - `rx_busy` pulses and returns to 0; nothing is pushed; `empty` stays 1.
- **Overrun.** FIFO_DEPTH=4; send 5 frames 0x01..0x05 without reading.
  - `full`=1 after the 4th; `overrun`=1 after the 5th.
  - Reads return 0x01..0x04.
  - `ovr_clr` → `overrun`=0.
  - Also run a push coincident with `rd_en` while full → no overrun.
- **Reset mid-frame.** Assert `reset` during DATA of frame 0x55.
  - All outputs return to reset values immediately; `empty`=1.
  - A frame 0x99 sent after deassertion is received intact.
